// File: rtl/change_dispenser.sv
// Coin-return stage: pays a validated change amount greedily as 20c/10c/5c
// pulses, gated by hopper readiness, with timed pulse and gap phases.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [5:0] change,
    input  logic       hopper_ready,
    output logic       r5,
    output logic       r10,
    output logic       r20,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] coin_count
);

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [5:0]    r_remaining;
    logic [2:0]    r_coin;      // one-hot {20c, 10c, 5c}; doubles as the output pins
    logic [TW-1:0] r_timer;
    logic [3:0]    r_count;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    state_t        w_state_next;
    logic [5:0]    w_remaining_next;
    logic [2:0]    w_coin_next;
    logic [TW-1:0] w_timer_next;
    logic [3:0]    w_count_next;
    logic          w_done_next;
    logic          w_err_next;
    logic          w_change_ok;
    logic [2:0]    w_pick_coin;
    logic [5:0]    w_pick_value;

    assign w_change_ok = (change <= 6'd60) && ((change % 6'd5) == 6'd0);

    // Remaining is always a multiple of 5, so a nonzero value below 10 is exactly 5.
    always_comb begin
        w_pick_coin  = 3'b001;
        w_pick_value = 6'd5;
        if (r_remaining >= 6'd20) begin
            w_pick_coin  = 3'b100;
            w_pick_value = 6'd20;
        end else if (r_remaining >= 6'd10) begin
            w_pick_coin  = 3'b010;
            w_pick_value = 6'd10;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_coin_next      = r_coin;
        w_timer_next     = r_timer;
        w_count_next     = r_count;
        w_done_next      = 1'b0;
        w_err_next       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_change_ok) begin
                        w_remaining_next = change;
                        w_count_next     = 4'd0;
                        w_state_next     = S_SELECT;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            S_SELECT: begin
                if (r_remaining == 6'd0) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                end else if (hopper_ready) begin
                    w_coin_next      = w_pick_coin;
                    w_remaining_next = r_remaining - w_pick_value;
                    w_count_next     = r_count + 4'd1;
                    w_timer_next     = PULSE_LOAD;
                    w_state_next     = S_PULSE;
                end
            end
            S_PULSE: begin
                if (r_timer == '0) begin
                    w_coin_next  = 3'b000;
                    w_timer_next = GAP_LOAD;
                    w_state_next = S_GAP;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            S_GAP: begin
                if (r_timer == '0) begin
                    w_state_next = S_SELECT;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_coin_next  = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_remaining <= 6'd0;
            r_coin      <= 3'b000;
            r_timer     <= '0;
            r_count     <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_coin      <= w_coin_next;
            r_timer     <= w_timer_next;
            r_count     <= w_count_next;
            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= w_done_next;
            r_err       <= w_err_next;
        end
    end

    assign r20        = r_coin[2];
    assign r10        = r_coin[1];
    assign r5         = r_coin[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign coin_count = r_count;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: timestamp-based payout model checked every cycle,
// plus directed scenarios with hand-computed edge expectations.
module tb_change_dispenser;

    localparam int P = 4;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [5:0] change;
    logic       hopper_ready;
    logic       r5, r10, r20, busy, done, err;
    logic [3:0] coin_count;

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .change(change),
        .hopper_ready(hopper_ready), .r5(r5), .r10(r10), .r20(r20),
        .busy(busy), .done(done), .err(err), .coin_count(coin_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: a transaction is a list of greedy coin values; each
    // coin issued at edge t is visible after edges t..t+P-1 and the next
    // coin decision happens at edge t+P+G+1.
    int cyc = 0;
    bit m_ok = 0;
    bit m_active = 0;
    int m_coins[$];
    int m_decide_at = -1;
    int m_idle_at = -1;
    int m_pulse_from = 0;
    int m_pulse_to = -1;
    int m_pulse_val = 0;
    int m_count = 0;
    int m_tx = 0;
    int e_coin = 0;
    bit e_done = 0;
    bit e_err = 0;

    always @(posedge clk) begin
        int c;
        cyc++;
        e_done = 0;
        e_err  = 0;
        if (!reset_n) begin
            m_ok = 1;
            m_active = 0;
            m_coins.delete();
            m_decide_at = -1;
            m_idle_at = -1;
            m_pulse_to = -1;
            m_count = 0;
        end else if (m_active) begin
            if (cyc == m_idle_at) begin
                m_active = 0;
            end else if (cyc == m_decide_at) begin
                if (m_coins.size() == 0) begin
                    e_done = 1;
                    m_idle_at = cyc + 1;
                    m_decide_at = -1;
                end else if (hopper_ready) begin
                    m_pulse_val = m_coins.pop_front();
                    m_pulse_from = cyc;
                    m_pulse_to = cyc + P - 1;
                    m_count++;
                    m_decide_at = cyc + P + G + 1;
                end else begin
                    m_decide_at = cyc + 1;
                end
            end
        end else if (start) begin
            c = int'(change);
            m_tx++;
            if (c <= 60 && c % 5 == 0) begin
                $display("tx %0d: edge %0d accepted change=%0d", m_tx, cyc, c);
                m_active = 1;
                m_count = 0;
                m_coins.delete();
                repeat (c / 20) m_coins.push_back(20);
                repeat ((c % 20) / 10) m_coins.push_back(10);
                repeat ((c % 10) / 5) m_coins.push_back(5);
                m_decide_at = cyc + 1;
                m_idle_at = -1;
            end else begin
                $display("tx %0d: edge %0d rejected change=%0d", m_tx, cyc, c);
                e_err = 1;
            end
        end
        e_coin = (cyc >= m_pulse_from && cyc <= m_pulse_to) ? m_pulse_val : 0;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("r20", int'(r20), int'(e_coin == 20));
            chk("r10", int'(r10), int'(e_coin == 10));
            chk("r5", int'(r5), int'(e_coin == 5));
            chk("busy", int'(busy), int'(m_active));
            chk("done", int'(done), int'(e_done));
            chk("err", int'(err), int'(e_err));
            chk("coin_count", int'(coin_count), m_count);
            chk("onehot", int'($countones({r5, r10, r20}) <= 1), 1);
        end
    end

    int base = 0;

    task automatic issue(input int c);
        start = 1'b1;
        change = 6'(c);
        base = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic at_edge(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        change = 6'd0;
        hopper_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(coin_count), 0);
        chk("reset_coins", int'({r20, r10, r5}), 0);
        @(negedge clk);

        // 35 -> 20, 10, 5
        issue(35);
        at_edge(1);  chk("c35_r20_e1", int'(r20), 1);
        at_edge(4);  chk("c35_r20_e4", int'(r20), 1);
        at_edge(5);  chk("c35_r20_e5", int'(r20), 0);
        at_edge(10); chk("c35_r10_e10", int'(r10), 1);
        at_edge(13); chk("c35_r10_e13", int'(r10), 1);
        at_edge(19); chk("c35_r5_e19", int'(r5), 1);
        at_edge(22); chk("c35_r5_e22", int'(r5), 1);
        at_edge(28); chk("c35_done", int'(done), 1);
                     chk("c35_count", int'(coin_count), 3);
        at_edge(29); chk("c35_idle", int'(busy), 0);
        wait_idle();

        // 60 -> three 20c
        issue(60);
        at_edge(1);  chk("c60_r20_e1", int'(r20), 1);
        at_edge(10); chk("c60_r20_e10", int'(r20), 1);
        at_edge(19); chk("c60_r20_e19", int'(r20), 1);
        at_edge(28); chk("c60_done", int'(done), 1);
                     chk("c60_count", int'(coin_count), 3);
        wait_idle();

        // 0 -> immediate done
        issue(0);
        at_edge(1); chk("c0_done", int'(done), 1);
                    chk("c0_count", int'(coin_count), 0);
        at_edge(2); chk("c0_idle", int'(busy), 0);
        wait_idle();

        // 37 -> error pulse
        issue(37);
        chk("c37_err", int'(err), 1);
        chk("c37_busy", int'(busy), 0);
        at_edge(1); chk("c37_err_gone", int'(err), 0);
                    chk("c37_nodone", int'(done), 0);
        wait_idle();

        // 15 with hopper stalls, and a drop mid-pulse
        hopper_ready = 1'b0;
        issue(15);
        at_edge(5);  chk("c15_r10_stalled", int'(r10), 0);
        hopper_ready = 1'b1;
        at_edge(6);  chk("c15_r10_e6", int'(r10), 1);
        at_edge(7);  hopper_ready = 1'b0;
        at_edge(9);  chk("c15_r10_e9", int'(r10), 1);
        at_edge(10); chk("c15_r10_e10", int'(r10), 0);
        at_edge(12); hopper_ready = 1'b1;
        at_edge(14); chk("c15_r5_e14", int'(r5), 0);
        at_edge(15); chk("c15_r5_e15", int'(r5), 1);
        at_edge(24); chk("c15_done", int'(done), 1);
        wait_idle();

        // reset during the second cycle of a 20c pulse
        issue(20);
        at_edge(1); chk("rst_r20_e1", int'(r20), 1);
        reset_n = 1'b0;
        at_edge(2); chk("rst_r20", int'(r20), 0);
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_count", int'(coin_count), 0);
        reset_n = 1'b1;
        @(negedge clk);
        issue(10);
        at_edge(1);  chk("after_rst_r10", int'(r10), 1);
        at_edge(10); chk("after_rst_done", int'(done), 1);
                     chk("after_rst_count", int'(coin_count), 1);
        wait_idle();

        // start while busy is ignored, including in the done cycle
        issue(45);
        at_edge(3);  start = 1'b1; change = 6'd5;
        at_edge(4);  start = 1'b0;
        at_edge(28); chk("c45_done", int'(done), 1);
                     chk("c45_count", int'(coin_count), 3);
        start = 1'b1; change = 6'd10;
        at_edge(29); start = 1'b0;
        at_edge(30); chk("c45_no_restart", int'(busy), 0);
        wait_idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) change = 6'($urandom_range(0, 63));
            else change = 6'(5 * $urandom_range(0, 12));
            hopper_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        reset_n = 1'b1;
        start = 1'b0;
        hopper_ready = 1'b1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequential coin-return stage downstream of the vending FSM and money counter. When a sale completes, it takes the 6-bit change amount in cents and pays it out greedily as 20c, 10c and 5c coins. Each coin is a timed one-hot pulse on `r20`/`r10`/`r5`, issued only while the coin hopper reports ready. It reports `busy` while paying, `done` at the end, and `err` for an unpayable amount.

## Interface
- `PULSE_CYCLES`, default 4: cycles each coin output is held high (≥1).
- `GAP_CYCLES`, default 4: cycles all coin outputs stay low after each pulse (≥1).
- `clk`, input, 1: sole clock, rising edge.
- `reset_n`, input, 1: synchronous reset, active low, sampled on rising `clk`.
- `start`, input, 1: request to pay `change`; sampled only in IDLE.
- `change`, input, 6: amount in cents, 0..60, must be a multiple of 5; sampled with `start`.
- `hopper_ready`, input, 1: hopper can accept a coin command.
- `r5`, `r10`, `r20`, output, 1 each: coin release pulses; at most one high at any time.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when payout is complete.
- `err`, output, 1: one-cycle pulse when `start` carried an invalid `change`.
- `coin_count`, output, 4: number of coins issued in the current or last transaction.

## Operation
- All outputs are registered.
- Reset (`reset_n`=0 at an edge) forces the following, taking effect at that edge even mid-pulse:
  - state IDLE;
  - `remaining`=0;
  - coin register cleared;
  - `r5`/`r10`/`r20`/`done`/`err`/`busy`=0;
  - `coin_count`=0.
- States are IDLE, SELECT, PULSE, GAP and DONE.
- IDLE:
  - `start`=1 with valid `change` loads `remaining`=`change`, clears `coin_count`, and moves to SELECT.
  - `start`=1 with invalid `change` (not a multiple of 5, or >60, i.e. 61..63 or e.g. 37) pulses `err` for one cycle and stays in IDLE; no coins are issued and `done` is not asserted.
- SELECT:
  - `remaining`=0 moves to DONE.
  - Otherwise the block picks the largest coin ≤ `remaining`, in priority order 20, 10, 5.
  - If `hopper_ready`=1, it loads the coin register, subtracts the coin value from `remaining`, increments `coin_count`, loads the timer with `PULSE_CYCLES`-1, and moves to PULSE.
  - If `hopper_ready`=0, it stays in SELECT; outputs stay low.
- PULSE:
  - The selected `r*` output is high.
  - The timer decrements each cycle; at 0 the block loads the timer with `GAP_CYCLES`-1 and moves to GAP.
  - `hopper_ready` is ignored during PULSE.
- GAP: all coin outputs are low; the timer decrements; at 0 the block moves to SELECT.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; no queuing.
- Changes to `change` after the sampling edge have no effect.
- Arithmetic:
  - `remaining` is 6 bits and never underflows, because a coin is chosen only if coin ≤ `remaining`.
  - `coin_count` is 4 bits; maximum 3 coins (60 = 3×20) per valid transaction.

## Timing
- Take the edge that samples `start` in IDLE as edge 0; the state is SELECT after edge 0.
- With `hopper_ready` held high, the first coin output is high after edge 1 for exactly `PULSE_CYCLES` cycles.
- Each coin then costs 1 + `PULSE_CYCLES` + `GAP_CYCLES` edges. With defaults that is 9 edges, so the next coin's SELECT is reached at edge 9n.
- After the last coin's GAP, SELECT sees `remaining`=0 and moves to DONE at the next edge:
  - `done` is high after edge 9n+1;
  - the block is back in IDLE (`busy`=0) after edge 9n+2.
- `change`=0: DONE after edge 1, IDLE after edge 2, no coin pulses.
- `hopper_ready` low in SELECT adds one cycle per low cycle. Deasserting it during PULSE or GAP has no effect on that coin.
- `err` is high in the cycle after edge 0; `busy` stays 0.
- A `start` sampled in the same cycle `done` is high is ignored, since the state is not IDLE. `start` is accepted from the cycle in which `busy` is low.

## Test plan
- Reset, then `change`=35 with `start` pulse and `hopper_ready`=1, defaults -> the following sequence:
  - `r20` high for edges 1..4 (4 cycles);
  - `r10` high after edges 10..13;
  - `r5` high after edges 19..22;
  - `done` high after edge 28;
  - `coin_count`=3;
  - never two `r*` outputs high together.
- `change`=60 -> three `r20` pulses 9 cycles apart, no `r10`/`r5`, `done` after edge 28, `coin_count`=3.
- `change`=0 -> `done` after edge 1, no coin pulses, `coin_count`=0. `change`=37 -> `err` for one cycle, `busy`=0, no `done`.
- `change`=15 with `hopper_ready`=0 for 5 cycles after edge 0 -> `r10` rises 5 cycles later than nominal. Dropping `hopper_ready` mid-PULSE leaves pulse width at 4.
- `reset_n`=0 during the second cycle of an `r20` pulse -> all outputs 0 after that edge, IDLE, `coin_count`=0. A new `start` with 10 then pays one `r10` normally.
- `start` re-pulsed with a different `change` while `busy` -> ignored; original payout completes unchanged.
